// File: rtl/gpio_input_conditioner_if.sv
// Event stream between the input conditioner (master) and its consumer (slave).
// Carries the FIFO head, the consumer's accept strobe and the sticky overflow flag.
interface gpio_input_conditioner_if #(
   parameter int unsigned CH_W = 5
) ();
   logic            evt_valid;
   logic [CH_W:0]   evt_data;
   logic            evt_ready;
   logic            evt_overflow;

   modport master (
      output evt_valid,
      output evt_data,
      output evt_overflow,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_data,
      input  evt_overflow,
      output evt_ready
   );
endinterface

// File: rtl/gpio_input_conditioner.sv
// GPIO front end: 2-FF sync, per-channel debounce, edge pulses, sticky pending bits and irq.
// Define EVENT_FIFO_EN to add the per-channel event queue feeding a first-word-fall-through FIFO.
module gpio_input_conditioner #(
   parameter int unsigned N_CH       = 20,
   parameter int unsigned DB_CYCLES  = 100000,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                sys_clock,
   input  logic                reset,
   input  logic [N_CH-1:0]     din,
   input  logic [2*N_CH-1:0]   edge_mode,
   input  logic [N_CH-1:0]     irq_en,
   input  logic [N_CH-1:0]     pend_clr,
   output logic [N_CH-1:0]     db_out,
   output logic [N_CH-1:0]     rise_pulse,
   output logic [N_CH-1:0]     fall_pulse,
   output logic [N_CH-1:0]     pending,
   output logic                irq,
   gpio_input_conditioner_if.master evt_if
);
   localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DB_CYCLES - 1);

   logic [N_CH-1:0]  sync1_q, sync2_q;
   logic [N_CH-1:0]  db_q, db_d, rise_q, rise_d, fall_q, fall_d;
   logic [N_CH-1:0]  pend_q, pend_d, qual, mode_rise, mode_fall;
   logic             irq_q, irq_d;
   logic [CNT_W-1:0] cnt_q [N_CH];
   logic [CNT_W-1:0] cnt_d [N_CH];

   always_comb begin
      db_d   = db_q;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < N_CH; i++) begin
         cnt_d[i]     = '0;
         mode_rise[i] = edge_mode[2*i];
         mode_fall[i] = edge_mode[2*i+1];
         // Accept the new level on the cycle the count would reach DB_CYCLES.
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CntLast) begin
               db_d[i]   = sync2_q[i];
               rise_d[i] = sync2_q[i];
               fall_d[i] = ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
      qual   = (rise_q & mode_rise) | (fall_q & mode_fall);
      pend_d = (pend_q & ~pend_clr) | qual;
      irq_d  = |(pend_q & irq_en);
   end

   always_ff @(posedge sys_clock) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         db_q    <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         pend_q  <= '0;
         irq_q   <= 1'b0;
         for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         pend_q  <= pend_d;
         irq_q   <= irq_d;
         for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign db_out     = db_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign pending    = pend_q;
   assign irq        = irq_q;

`ifdef EVENT_FIFO_EN
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned FCNT_W = PTR_W + 1;

   logic [N_CH-1:0]   req_q, req_d, redge_q, redge_d, grant;
   logic [CH_W:0]     mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic              ovf_q, ovf_d, push, pop, full, empty, found;
   logic [CH_W-1:0]   grant_idx;

   always_comb begin
      empty     = (fcnt_q == '0);
      full      = (fcnt_q == FCNT_W'(FIFO_DEPTH));
      pop       = ~empty & evt_if.evt_ready;
      found     = 1'b0;
      grant_idx = '0;
      grant     = '0;
      // Descending scan so the lowest requesting index is the one left standing.
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (req_q[i]) begin
            found     = 1'b1;
            grant_idx = CH_W'(i);
         end
      end
      push    = found & (~full | pop);
      req_d   = req_q;
      redge_d = redge_q;
      ovf_d   = ovf_q;
      if (push) begin
         grant[grant_idx] = 1'b1;
         req_d[grant_idx] = 1'b0;
      end
      for (int i = 0; i < N_CH; i++) begin
         if (qual[i]) begin
            if (req_q[i] && !grant[i]) ovf_d = 1'b1;
            req_d[i]   = 1'b1;
            redge_d[i] = rise_q[i];
         end
      end
      wr_d   = wr_q + PTR_W'(push);
      rd_d   = rd_q + PTR_W'(pop);
      fcnt_d = fcnt_q + FCNT_W'(push) - FCNT_W'(pop);
   end

   always_ff @(posedge sys_clock) begin
      if (!reset) begin
         req_q   <= '0;
         redge_q <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         fcnt_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         req_q   <= req_d;
         redge_q <= redge_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         fcnt_q  <= fcnt_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge sys_clock) begin
      if (push) mem_q[wr_q] <= {redge_q[grant_idx], grant_idx};
   end

   assign evt_if.evt_valid    = ~empty;
   assign evt_if.evt_data     = empty ? '0 : mem_q[rd_q];
   assign evt_if.evt_overflow = ovf_q;
`else
   localparam int unsigned unused_fifo_depth = FIFO_DEPTH;
   logic unused_evt_ready;

   assign unused_evt_ready    = evt_if.evt_ready;
   assign evt_if.evt_valid    = 1'b0;
   assign evt_if.evt_data     = '0;
   assign evt_if.evt_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner (N_CH=20, DB_CYCLES=4, FIFO_DEPTH=4).
// Event FIFO scenarios are checked against the EVENT_FIFO_EN build when that macro is defined.
module tb_gpio_input_conditioner;
   localparam int unsigned N_CH = 20;
   localparam int unsigned CH_W = 5;

   logic              sys_clock = 1'b0;
   logic              reset;
   logic [N_CH-1:0]   din;
   logic [2*N_CH-1:0] edge_mode;
   logic [N_CH-1:0]   irq_en, pend_clr;
   logic [N_CH-1:0]   db_out, rise_pulse, fall_pulse, pending;
   logic              irq;
   int                n_checks = 0;
   int                n_fail = 0;

   gpio_input_conditioner_if #(.CH_W(CH_W)) evt_if ();

   gpio_input_conditioner #(
      .N_CH       (N_CH),
      .DB_CYCLES  (4),
      .FIFO_DEPTH (4)
   ) dut (
      .sys_clock  (sys_clock),
      .reset      (reset),
      .din        (din),
      .edge_mode  (edge_mode),
      .irq_en     (irq_en),
      .pend_clr   (pend_clr),
      .db_out     (db_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .pending    (pending),
      .irq        (irq),
      .evt_if     (evt_if)
   );

   always #5 sys_clock = ~sys_clock;

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge sys_clock);
         #1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b0; din = '0; edge_mode = '0; irq_en = '0; pend_clr = '0;
      evt_if.evt_ready = 1'b0;
      tick(3);
      n_checks++;
      if ({db_out, rise_pulse, fall_pulse, pending, irq} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got db=%h r=%h f=%h p=%h irq=%b, want all 0",
                  db_out, rise_pulse, fall_pulse, pending, irq);
      end
      n_checks++;
      if ({evt_if.evt_valid, evt_if.evt_data, evt_if.evt_overflow} !== '0) begin
         n_fail++;
         $display("FAIL reset_evt: got v=%b d=%h o=%b, want 0", evt_if.evt_valid,
                  evt_if.evt_data, evt_if.evt_overflow);
      end
      reset = 1'b1;
   endtask

   task automatic test_debounce_latency;
      din[0] = 1'b1;
      tick(5);
      n_checks++;
      if (db_out[0] !== 1'b0 || rise_pulse[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_early: got db=%b rise=%b at 5 cycles, want 0 0",
                  db_out[0], rise_pulse[0]);
      end
      tick();
      n_checks++;
      if (db_out[0] !== 1'b1 || rise_pulse[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL latency_6: got db=%b rise=%b at 6 cycles, want 1 1",
                  db_out[0], rise_pulse[0]);
      end
      tick();
      n_checks++;
      if (rise_pulse[0] !== 1'b0 || db_out[0] !== 1'b1 || pending[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL rise_one_cycle: got rise=%b db=%b pend=%b, want 0 1 0",
                  rise_pulse[0], db_out[0], pending[0]);
      end
   endtask

   task automatic test_glitch;
      din[3] = 1'b1;
      tick(3);
      din[3] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         n_checks++;
         if (db_out[3] !== 1'b0 || rise_pulse[3] !== 1'b0 || fall_pulse[3] !== 1'b0 ||
             pending[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_ch3 cycle %0d: got db=%b r=%b f=%b p=%b, want 0 0 0 0",
                     k, db_out[3], rise_pulse[3], fall_pulse[3], pending[3]);
         end
      end
   endtask

   task automatic test_pending_irq;
      edge_mode[1:0] = 2'b01;
      irq_en[0] = 1'b1;
      din[0] = 1'b0;
      tick(6);
      n_checks++;
      if (fall_pulse[0] !== 1'b1 || db_out[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL fall_ch0: got fall=%b db=%b, want 1 0", fall_pulse[0], db_out[0]);
      end
      din[0] = 1'b1;
      tick();
      n_checks++;
      if (pending[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL unqualified_fall: got pend=%b, want 0", pending[0]);
      end
      tick(5);
      tick();
      n_checks++;
      if (pending[0] !== 1'b1 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL pend_set: got pend=%b irq=%b, want 1 0", pending[0], irq);
      end
      tick();
      n_checks++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_set: got irq=%b, want 1", irq);
      end
      din[0] = 1'b0;
      tick(6);
      din[0] = 1'b1;
      tick(6);
      pend_clr[0] = 1'b1;
      tick();
      pend_clr[0] = 1'b0;
      n_checks++;
      if (pending[0] !== 1'b1 || irq !== 1'b1) begin
         n_fail++;
         $display("FAIL set_wins: got pend=%b irq=%b, want 1 1", pending[0], irq);
      end
      pend_clr[0] = 1'b1;
      tick();
      pend_clr[0] = 1'b0;
      n_checks++;
      if (pending[0] !== 1'b0 || irq !== 1'b1) begin
         n_fail++;
         $display("FAIL lone_clear: got pend=%b irq=%b, want 0 1", pending[0], irq);
      end
      tick();
      n_checks++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_clear: got irq=%b, want 0", irq);
      end
   endtask

   task automatic test_reset_mid_debounce;
      din[5] = 1'b1;
      tick(4);
      reset = 1'b0;
      tick();
      n_checks++;
      if ({db_out, rise_pulse, fall_pulse, pending, irq} !== '0) begin
         n_fail++;
         $display("FAIL mid_reset: got db=%h r=%h f=%h p=%h irq=%b, want all 0",
                  db_out, rise_pulse, fall_pulse, pending, irq);
      end
      reset = 1'b1;
      tick(5);
      n_checks++;
      if (db_out[5] !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_early: got db5=%b, want 0", db_out[5]);
      end
      tick();
      n_checks++;
      if (db_out[5] !== 1'b1 || rise_pulse[5] !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_rise: got db5=%b rise5=%b, want 1 1",
                  db_out[5], rise_pulse[5]);
      end
   endtask

   task automatic test_fifo_pair;
      evt_if.evt_ready = 1'b1;
      edge_mode[5:4] = 2'b01;
      edge_mode[15:14] = 2'b01;
      din[2] = 1'b1;
      din[7] = 1'b1;
      tick(6);
      n_checks++;
      if (rise_pulse !== 20'h00084) begin
         n_fail++;
         $display("FAIL pair_rise: got %h, want 00084", rise_pulse);
      end
      tick();
`ifdef EVENT_FIFO_EN
      n_checks++;
      if (evt_if.evt_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL pair_not_yet: got valid=%b, want 0", evt_if.evt_valid);
      end
      tick();
      n_checks++;
      if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== 6'h22) begin
         n_fail++;
         $display("FAIL pair_first: got v=%b d=%h, want 1 22", evt_if.evt_valid,
                  evt_if.evt_data);
      end
      tick();
      n_checks++;
      if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== 6'h27) begin
         n_fail++;
         $display("FAIL pair_second: got v=%b d=%h, want 1 27", evt_if.evt_valid,
                  evt_if.evt_data);
      end
      tick();
      n_checks++;
      if (evt_if.evt_valid !== 1'b0 || evt_if.evt_data !== 6'h00) begin
         n_fail++;
         $display("FAIL pair_empty: got v=%b d=%h, want 0 00", evt_if.evt_valid,
                  evt_if.evt_data);
      end
`else
      tick(3);
      n_checks++;
      if ({evt_if.evt_valid, evt_if.evt_data, evt_if.evt_overflow} !== '0) begin
         n_fail++;
         $display("FAIL no_fifo_evt: got v=%b d=%h o=%b, want 0", evt_if.evt_valid,
                  evt_if.evt_data, evt_if.evt_overflow);
      end
`endif
      n_checks++;
      if (pending[2] !== 1'b1 || pending[7] !== 1'b1) begin
         n_fail++;
         $display("FAIL pair_pending: got p2=%b p7=%b, want 1 1", pending[2], pending[7]);
      end
      evt_if.evt_ready = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [CH_W:0] exp_seq [6];
      exp_seq = '{6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h0D};
      edge_mode[27:16] = 12'hFFF;
      din[13:8] = 6'h3F;
      tick(6);
      n_checks++;
      if (rise_pulse !== 20'h03F00) begin
         n_fail++;
         $display("FAIL burst_rise: got %h, want 03F00", rise_pulse);
      end
      tick(5);
      din[13] = 1'b0;
      tick(6);
      n_checks++;
      if (fall_pulse[13] !== 1'b1) begin
         n_fail++;
         $display("FAIL burst_fall13: got %b, want 1", fall_pulse[13]);
      end
      tick();
`ifdef EVENT_FIFO_EN
      n_checks++;
      if (evt_if.evt_overflow !== 1'b1 || evt_if.evt_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow: got o=%b v=%b, want 1 1", evt_if.evt_overflow,
                  evt_if.evt_valid);
      end
      evt_if.evt_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         n_checks++;
         if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== exp_seq[k]) begin
            n_fail++;
            $display("FAIL drain_%0d: got v=%b d=%h, want 1 %h", k, evt_if.evt_valid,
                     evt_if.evt_data, exp_seq[k]);
         end
         tick();
      end
      n_checks++;
      if (evt_if.evt_valid !== 1'b0 || evt_if.evt_overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL drain_done: got v=%b o=%b, want 0 1", evt_if.evt_valid,
                  evt_if.evt_overflow);
      end
      evt_if.evt_ready = 1'b0;
`else
      evt_if.evt_ready = 1'b1;
      tick();
      n_checks++;
      if ({evt_if.evt_valid, evt_if.evt_data, evt_if.evt_overflow} !== '0 ||
          exp_seq[0] !== 6'h28) begin
         n_fail++;
         $display("FAIL no_fifo_burst: got v=%b d=%h o=%b, want 0", evt_if.evt_valid,
                  evt_if.evt_data, evt_if.evt_overflow);
      end
      evt_if.evt_ready = 1'b0;
`endif
      n_checks++;
      if (pending[13:8] !== 6'h3F) begin
         n_fail++;
         $display("FAIL burst_pending: got %h, want 3f", pending[13:8]);
      end
   endtask

   initial begin
      test_reset();
      test_debounce_latency();
      test_glitch();
      test_pending_irq();
      test_reset_mid_debounce();
      test_fifo_pair();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
